// File: rtl/eth_sb_axi_pkg.sv
// Shared types and constants for the sideband-to-AXI request bridge.
// Optional watchdog is enabled with the ETH_SB_AXI_TIMEOUT_EN macro.
package eth_sb_axi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StDone = 2'd3
  } state_e;

  // Response code field i_axi_sresp[2:1] and the write-response flag bit
  localparam logic [1:0]  SRESP_OK     = 2'b00;
  localparam logic [1:0]  SRESP_SLVERR = 2'b10;
  localparam logic [1:0]  SRESP_DECERR = 2'b11;
  localparam int unsigned SRESP_WR_BIT = 0;

  localparam logic [1:0] STATUS_OK     = 2'b00;
  localparam logic [1:0] STATUS_TYPE   = 2'b01;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_DECERR = 2'b11;

  // Reserved response codes are reported as DECERR.
  function automatic logic [1:0] decode_status(input logic [2:0] sresp, input logic is_write);
    case (sresp[2:1])
      SRESP_OK:     decode_status = (sresp[SRESP_WR_BIT] != is_write) ? STATUS_TYPE : STATUS_OK;
      SRESP_SLVERR: decode_status = STATUS_SLVERR;
      SRESP_DECERR: decode_status = STATUS_DECERR;
      default:      decode_status = STATUS_DECERR;
    endcase
  endfunction

endpackage

// File: rtl/eth_sb_axi_wdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags the LIMIT-th one.
// Instantiated by the bridge only when ETH_SB_AXI_TIMEOUT_EN is defined.
module eth_sb_axi_wdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = i_enable && !i_clear && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/eth_sb_axi_bridge.sv
// Sideband-to-AXI request bridge: one core request in flight, all outputs registered.
// Define ETH_SB_AXI_TIMEOUT_EN to add the watchdog and late-response drain.
module eth_sb_axi_bridge
  import eth_sb_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_fuse_enable,
  input  logic                    i_core_valid,
  input  logic [ADDR_WIDTH-1:0]   i_core_addr,
  input  logic [DATA_WIDTH-1:0]   i_core_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_core_wstrb,
  output logic                    o_core_ready,
  output logic [DATA_WIDTH-1:0]   o_core_rdata,
  output logic [1:0]              o_core_status,
  output logic                    o_axi_mread,
  output logic                    o_axi_mwrite,
  output logic [ADDR_WIDTH-1:0]   o_axi_maddr,
  output logic [DATA_WIDTH-1:0]   o_axi_mdata,
  output logic [DATA_WIDTH/8-1:0] o_axi_mwstrb,
  input  logic                    i_axi_saccept,
  input  logic                    i_axi_svalid,
  input  logic [2:0]              i_axi_sresp,
  input  logic [DATA_WIDTH-1:0]   i_axi_sdata,
  output logic                    o_axi_mready,
  output logic                    o_axi_timeout
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  state_e              r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_d;
  logic                  r_flush, w_flush_d;
  logic [DATA_WIDTH-1:0] w_rdata_d;
  logic [1:0]            w_status_d;
  logic                  w_timeout_d, w_capture, w_drain, w_expire, w_is_write;
  logic                  w_req_d, w_wr_d, w_mwrite_d;

  assign w_is_write = |r_wstrb;
  assign w_capture  = (r_state == StIdle) && i_core_valid && !i_fuse_enable && !r_flush;
  // mready is only high outside RESP while flushing, so this is the abandoned response
  assign w_drain    = r_flush && o_axi_mready && i_axi_svalid;

`ifdef ETH_SB_AXI_TIMEOUT_EN
  eth_sb_axi_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_capture),
    .i_enable  ((r_state == StReq) || (r_state == StResp)),
    .o_expire  (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_expire         = 1'b0;
`endif

  assign w_addr_d  = w_capture ? i_core_addr  : r_addr;
  assign w_wdata_d = w_capture ? i_core_wdata : r_wdata;
  assign w_wstrb_d = w_capture ? i_core_wstrb : r_wstrb;

  always_comb begin
    w_state_d   = r_state;
    w_timeout_d = 1'b0;
    w_rdata_d   = o_core_rdata;
    w_status_d  = o_core_status;
    w_flush_d   = w_drain ? 1'b0 : r_flush;
    case (r_state)
      StIdle: if (w_capture) w_state_d = StReq;
      StReq: begin
        if (i_axi_saccept) begin
          w_state_d = StResp;
        end else if (w_expire) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b1;
        end
      end
      StResp: begin
        if (i_axi_svalid) begin
          w_state_d  = StDone;
          w_rdata_d  = w_is_write ? '0 : i_axi_sdata;
          w_status_d = decode_status(i_axi_sresp, w_is_write);
        end else if (w_expire) begin
          w_state_d   = StDone;
          w_timeout_d = 1'b1;
          w_flush_d   = 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_timeout_d) begin
      w_rdata_d  = '1;
      w_status_d = STATUS_DECERR;
    end
  end

  assign w_req_d    = (w_state_d == StReq);
  assign w_wr_d     = |w_wstrb_d;
  assign w_mwrite_d = w_req_d && w_wr_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_flush       <= 1'b0;
      o_core_ready  <= 1'b0;
      o_core_rdata  <= '0;
      o_core_status <= '0;
      o_axi_mread   <= 1'b0;
      o_axi_mwrite  <= 1'b0;
      o_axi_maddr   <= '0;
      o_axi_mdata   <= '0;
      o_axi_mwstrb  <= '0;
      o_axi_mready  <= 1'b0;
      o_axi_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_addr        <= w_addr_d;
      r_wdata       <= w_wdata_d;
      r_wstrb       <= w_wstrb_d;
      r_flush       <= w_flush_d;
      o_core_ready  <= (w_state_d == StDone);
      o_core_rdata  <= w_rdata_d;
      o_core_status <= w_status_d;
      o_axi_mread   <= w_req_d && !w_wr_d;
      o_axi_mwrite  <= w_mwrite_d;
      o_axi_maddr   <= w_req_d ? w_addr_d : '0;
      o_axi_mdata   <= w_mwrite_d ? w_wdata_d : '0;
      o_axi_mwstrb  <= w_mwrite_d ? w_wstrb_d : '0;
      o_axi_mready  <= (w_state_d == StResp) || ((w_state_d == StIdle) && w_flush_d);
      o_axi_timeout <= w_timeout_d;
    end
  end

endmodule

// File: tb/tb_eth_sb_axi_bridge.sv
// Directed bench for eth_sb_axi_bridge; the watchdog sequence runs when
// ETH_SB_AXI_TIMEOUT_EN is defined (instance uses TIMEOUT_CYCLES=8).
module tb_eth_sb_axi_bridge;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fuse, valid, saccept, svalid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, sdata;
  logic [SW-1:0] wstrb;
  logic [2:0]    sresp;
  logic          core_ready, mread, mwrite, mready, tmo;
  logic [DW-1:0] rdata, mdata;
  logic [1:0]    status;
  logic [AW-1:0] maddr;
  logic [SW-1:0] mwstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eth_sb_axi_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_fuse_enable (fuse),
    .i_core_valid  (valid),
    .i_core_addr   (addr),
    .i_core_wdata  (wdata),
    .i_core_wstrb  (wstrb),
    .o_core_ready  (core_ready),
    .o_core_rdata  (rdata),
    .o_core_status (status),
    .o_axi_mread   (mread),
    .o_axi_mwrite  (mwrite),
    .o_axi_maddr   (maddr),
    .o_axi_mdata   (mdata),
    .o_axi_mwstrb  (mwstrb),
    .i_axi_saccept (saccept),
    .i_axi_svalid  (svalid),
    .i_axi_sresp   (sresp),
    .i_axi_sdata   (sdata),
    .o_axi_mready  (mready),
    .o_axi_timeout (tmo)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            acc_dly;
    int            rsp_dly;
    logic [2:0]    sresp;
    logic [DW-1:0] sdata;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_status;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    any_out = |{core_ready, rdata, status, mread, mwrite, maddr, mdata, mwstrb, mready, tmo};
  endfunction

  task automatic run_txn(input vec_t v, input int id);
    int            req_cyc, rsp_cyc;
    bit            done;
    logic          is_wr;
    logic [DW-1:0] exp_mdata;
    logic [SW-1:0] exp_mwstrb;
    is_wr      = (v.wstrb != 0);
    exp_mdata  = is_wr ? v.wdata : '0;
    exp_mwstrb = is_wr ? v.wstrb : '0;
    @(negedge clk);
    valid = 1'b1; addr = v.addr; wdata = v.wdata; wstrb = v.wstrb;
    req_cyc = 0; rsp_cyc = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      saccept = 1'b0;
      svalid  = 1'b0;
      if (mread || mwrite) begin
        if (req_cyc == 0) begin
          check($sformatf("v%0d.kind", id), {mread, mwrite}, {!is_wr, is_wr});
          check($sformatf("v%0d.maddr", id), maddr, v.addr);
          check($sformatf("v%0d.mdata", id), mdata, exp_mdata);
          check($sformatf("v%0d.mwstrb", id), mwstrb, exp_mwstrb);
        end
        req_cyc++;
        saccept = (req_cyc > v.acc_dly);
      end
      if (mready) begin
        rsp_cyc++;
        if (rsp_cyc > v.rsp_dly) begin
          svalid = 1'b1; sresp = v.sresp; sdata = v.sdata;
        end
      end
      if (core_ready) begin
        check($sformatf("v%0d.rdata", id), rdata, v.exp_rdata);
        check($sformatf("v%0d.status", id), status, v.exp_status);
        check($sformatf("v%0d.timeout", id), tmo, 0);
        valid = 1'b0;
        done  = 1'b1;
      end
    end
    check($sformatf("v%0d.done", id), done, 1);
    check($sformatf("v%0d.req_cycles", id), req_cyc, v.acc_dly + 1);
    @(negedge clk);
    check($sformatf("v%0d.ready_pulse", id), core_ready, 0);
  endtask

  initial begin
    int r1, r2, rd_after, cyc, hits;
    bit seen;
    vecs[0] = '{24'h000040, 32'h0,        4'b0000, 2, 1, 3'b000, 32'hA5A5_1234, 32'hA5A5_1234, 2'b00};
    vecs[1] = '{24'h000100, 32'hCAFE_F00D, 4'b0011, 0, 0, 3'b001, 32'h1234_5678, 32'h0,         2'b00};
    vecs[2] = '{24'h000204, 32'h0,        4'b0000, 1, 0, 3'b100, 32'hDEAD_0001, 32'hDEAD_0001, 2'b10};
    vecs[3] = '{24'h000308, 32'h1111_2222, 4'b1111, 0, 2, 3'b111, 32'h5555_5555, 32'h0,         2'b11};
    vecs[4] = '{24'h00040C, 32'h0,        4'b0000, 0, 0, 3'b001, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 2'b01};
    vecs[5] = '{24'hFFFFFC, 32'h55AA_55AA, 4'b1000, 3, 0, 3'b000, 32'h0,         32'h0,         2'b01};
    vecs[6] = '{24'h123456, 32'h0,        4'b0000, 0, 1, 3'b010, 32'h7777_7777, 32'h7777_7777, 2'b11};

    rst_n = 1'b0; fuse = 1'b0; valid = 1'b0; saccept = 1'b0; svalid = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; sresp = '0; sdata = '0;
    repeat (2) @(negedge clk);
    check("reset.outputs", any_out(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.outputs", any_out(), 0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Back-to-back: valid held across two reads, subordinate always ready.
    @(negedge clk);
    valid = 1'b1; addr = 24'h000080; wstrb = '0; saccept = 1'b1; svalid = 1'b1;
    sresp = 3'b000; sdata = 32'h0000_00B2;
    r1 = -1; r2 = -1; rd_after = -1;
    for (int c = 1; c <= 20 && r2 < 0; c++) begin
      @(negedge clk);
      if (core_ready) begin
        if (r1 < 0) r1 = c;
        else begin
          r2 = c;
          valid = 1'b0;
        end
      end
      if (mread && r1 >= 0 && rd_after < 0) rd_after = c;
    end
    saccept = 1'b0; svalid = 1'b0;
    check("b2b.first_ready", r1, 3);
    check("b2b.second_ready", r2, 7);
    check("b2b.second_req", rd_after, r1 + 2);

    // Fuse blocks new captures.
    @(negedge clk);
    fuse = 1'b1; valid = 1'b1; addr = 24'h000010; wstrb = 4'b0001;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mread || mwrite || core_ready) hits++;
    end
    check("fuse.no_activity", hits, 0);
    valid = 1'b0; fuse = 1'b0;

    // Reset asserted while waiting for a response.
    @(negedge clk);
    valid = 1'b1; addr = 24'h000020; wstrb = '0;
    @(negedge clk);
    check("rst_mid.mread", mread, 1);
    saccept = 1'b1;
    @(negedge clk);
    saccept = 1'b0; valid = 1'b0;
    check("rst_mid.mready", mready, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs", any_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (any_out()) hits++;
    end
    check("rst_mid.quiet", hits, 0);

`ifdef ETH_SB_AXI_TIMEOUT_EN
    // Accepted read never answered: expiry on the 8th REQ/RESP cycle.
    @(negedge clk);
    valid = 1'b1; addr = 24'h000050; wstrb = '0;
    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      saccept = mread;
      if (core_ready) begin
        seen = 1'b1; cyc = c;
        check("tmo.pulse", tmo, 1);
        check("tmo.status", status, 2'b11);
        check("tmo.rdata", rdata, 32'hFFFF_FFFF);
        addr = 24'h000060;
      end
    end
    saccept = 1'b0;
    check("tmo.seen", seen, 1);
    check("tmo.cycle", cyc, 9);
    repeat (3) @(negedge clk);
    check("drain.mready", mready, 1);
    check("drain.blocked", mread, 0);
    svalid = 1'b1; sresp = 3'b000; sdata = 32'h0000_0099;
    @(negedge clk);
    svalid = 1'b0;
    check("drain.done_mready", mready, 0);
    check("drain.no_ready", core_ready, 0);
    @(negedge clk);
    check("drain.next_mread", mread, 1);
    check("drain.next_maddr", maddr, 24'h000060);
    saccept = 1'b1;
    @(negedge clk);
    saccept = 1'b0; svalid = 1'b1; sdata = 32'h0000_0042;
    @(negedge clk);
    svalid = 1'b0; valid = 1'b0;
    check("drain.next_ready", core_ready, 1);
    check("drain.next_rdata", rdata, 32'h0000_0042);
    check("drain.next_status", status, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
